jk_reg_bank: RTL and testbench
==============================

JK_REG_BANK -- requirements
Module: jk_reg_bank

Interface
REQ-001 Parameter WIDTH, default 8, number of JK bits in the bank (1..64).
REQ-002 Parameter RST_VAL, default {WIDTH{1'b0}}, value loaded into q on reset.
REQ-003 Parameter CNT_W, default 8, width of the toggle-event counter (2..32).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  JK update enable; when 0, q holds.
REQ-007 j  input  WIDTH  per-bit J inputs.
REQ-008 k  input  WIDTH  per-bit K inputs.
REQ-009 load  input  1  synchronous parallel load strobe.
REQ-010 d  input  WIDTH  parallel load data.
REQ-011 clr_cnt  input  1  synchronous clear of tog_cnt and tog_sat.
REQ-012 q  output  WIDTH  registered bank state.
REQ-013 qn  output  WIDTH  bitwise complement of q, combinational from q.
REQ-014 chg  output  1  registered; 1 for one cycle after any edge at which q changed value.
REQ-015 tog_cnt  output  CNT_W  saturating count of toggle events.
REQ-016 tog_sat  output  1  registered; 1 while tog_cnt equals 2^CNT_W-1.
REQ-017 q_par  output  1  even parity of q (see Configuration).

Function
REQ-018 Update priority at each edge SHALL be: rst > load > en > hold.
REQ-019 load=1: q <= d, regardless of en, j, k.
REQ-020 load=0, en=1, per bit i: j=0,k=0 hold; j=0,k=1 q[i]<=0; j=1,k=0 q[i]<=1; j=1,k=1 q[i]<=~q[i].
REQ-021 load=0, en=0: q holds; j/k ignored.
REQ-022 q SHALL update with one-edge latency from inputs; no combinational path from j/k/d/load/en to q.
REQ-023 chg <= (q_next != q) at every edge; chg=0 after a load of d equal to the current q.
REQ-024 Toggle event: an edge with load=0, en=1 and (j & k) != 0; counts once per edge, regardless of how many bits toggle.
REQ-025 tog_cnt increments by 1 per toggle event; at 2^CNT_W-1 it holds (no wrap).
REQ-026 clr_cnt=1 sets tog_cnt<=0, tog_sat<=0; clr_cnt wins over a simultaneous toggle event.
REQ-027 tog_sat SHALL be registered coincident with tog_cnt reaching or holding at max.
REQ-028 clr_cnt SHALL NOT affect q or chg; load/en SHALL NOT affect the counter except as defined in REQ-024.

Reset
REQ-029 With rst=1 at an edge: q<=RST_VAL, chg<=0, tog_cnt<=0, tog_sat<=0, q_par<=parity(RST_VAL) or 0 per Configuration.
REQ-030 rst SHALL override load, en, j, k and clr_cnt in the same cycle; reset mid-count discards the count.
REQ-031 Outputs before the first reset edge are undefined; the bench SHALL apply rst for at least one edge.

Configuration
REQ-032 Macro JK_REG_BANK_PARITY_EN defined: q_par is a register updated every edge with the XOR of all bits of q_next (even parity, coincident with q).
REQ-033 Macro undefined: no parity register is built; q_par is tied to 0.

Verification
REQ-034 WIDTH=8: rst=1 one edge -> q=8'h00, qn=8'hFF, chg=0, tog_cnt=0, tog_sat=0.
REQ-035 en=1, j=8'hF0, k=8'h0F from q=8'h00 -> q=8'hF0, chg=1; repeat the same inputs -> q=8'hF0, chg=0.
REQ-036 en=1, j=k=8'hFF for 3 edges from q=8'hF0 -> q=8'h0F,8'hF0,8'h0F; tog_cnt=3.
REQ-037 load=1, d=8'hA5, en=1, j=k=8'hFF -> q=8'hA5, tog_cnt unchanged; with PARITY_EN q_par=0; without, q_par=0 always; load d=8'hA4 -> q_par=1 with PARITY_EN.
REQ-038 CNT_W=2: 5 toggle edges -> tog_cnt 1,2,3,3,3, tog_sat=1 from 3rd edge; then clr_cnt=1 with toggle active -> tog_cnt=0, tog_sat=0.
REQ-039 rst=1 together with load=1, d=8'h55, clr_cnt=0, toggle active -> q=RST_VAL, tog_cnt=0, chg=0.

Source files
------------

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: WIDTH JK flip-flops with parallel load, change flag and a saturating
// toggle-event counter. Define JK_REG_BANK_PARITY_EN to build the registered even-parity output q_par.
module jk_reg_bank #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
   parameter int               CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             clr_cnt,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic             chg,
   output logic [CNT_W-1:0] tog_cnt,
   output logic             tog_sat,
   output logic             q_par
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] q_next;
   logic [CNT_W-1:0] cnt_next;
   logic             tog_evt;

   // Load beats the JK update; JK per bit is q+ = j&~q | ~k&q.
   always_comb begin
      // NOTE: default assignment first so every path drives q_next and no latch is inferred.
      q_next = q;
      if (load) begin
         q_next = d;
      end else if (en) begin
         q_next = (j & ~q) | (~k & q);
      end
   end

   // One event per edge no matter how many bits toggle.
   assign tog_evt = ~load & en & (|(j & k));

   always_comb begin
      cnt_next = tog_cnt;
      if (clr_cnt) begin
         cnt_next = '0;
      end else if (tog_evt && (tog_cnt != CNT_MAX)) begin
         cnt_next = tog_cnt + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         q       <= RST_VAL;
         chg     <= 1'b0;
         tog_cnt <= '0;
         tog_sat <= 1'b0;
      end else begin
         q       <= q_next;
         chg     <= (q_next != q);
         tog_cnt <= cnt_next;
         tog_sat <= (cnt_next == CNT_MAX);
      end
   end

   assign qn = ~q;

`ifdef JK_REG_BANK_PARITY_EN
   // Parity of q_next keeps q_par coincident with q.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_par <= ^RST_VAL;
      end else begin
         q_par <= ^q_next;
      end
   end
`else
   assign q_par = 1'b0;
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
// Self-checking bench for jk_reg_bank: directed scenarios plus a reference-model scoreboard
// covering a default instance (CNT_W=8) and a CNT_W=2 instance sharing the same stimulus.
module tb_jk_reg_bank;

   typedef struct {
      string      tag;
      logic [7:0] q;
      logic       chg;
      logic [7:0] cnt8;
      logic       sat8;
      logic [1:0] cnt2;
      logic       sat2;
      logic       par;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst, en, load, clr_cnt;
   logic [7:0] j, k, d;

   logic [7:0] q8, qn8, q2, qn2;
   logic       chg8, chg2, sat8, sat2, par8, par2;
   logic [7:0] cnt8;
   logic [1:0] cnt2;

   int n_checks = 0;
   int n_fail   = 0;

   exp_t sb[$];

   // Reference model state
   logic [7:0] m_q;
   logic [7:0] m_cnt8;
   logic [1:0] m_cnt2;

   always #5 clk = ~clk;

   jk_reg_bank u_dut (
      .clk(clk), .rst(rst), .en(en), .j(j), .k(k), .load(load), .d(d), .clr_cnt(clr_cnt),
      .q(q8), .qn(qn8), .chg(chg8), .tog_cnt(cnt8), .tog_sat(sat8), .q_par(par8)
   );

   jk_reg_bank #(.WIDTH(8), .RST_VAL(8'h00), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .en(en), .j(j), .k(k), .load(load), .d(d), .clr_cnt(clr_cnt),
      .q(q2), .qn(qn2), .chg(chg2), .tog_cnt(cnt2), .tog_sat(sat2), .q_par(par2)
   );

   // Push the model's expectation for the coming edge, then advance one clock.
   task automatic cyc(input string tag);
      exp_t       e;
      logic [7:0] nq;
      logic       tog;
      nq = m_q;
      if (load) begin
         nq = d;
      end else if (en) begin
         for (int i = 0; i < 8; i++) begin
            case ({j[i], k[i]})
               2'b01:   nq[i] = 1'b0;
               2'b10:   nq[i] = 1'b1;
               2'b11:   nq[i] = ~m_q[i];
               default: nq[i] = m_q[i];
            endcase
         end
      end
      tog = !load && en && ((j & k) != 8'h00);
      e.tag = tag;
      if (rst) begin
         e.chg = 1'b0;
         nq = 8'h00;
         m_cnt8 = 8'd0;
         m_cnt2 = 2'd0;
      end else begin
         e.chg = (nq != m_q);
         if (clr_cnt) begin
            m_cnt8 = 8'd0;
            m_cnt2 = 2'd0;
         end else if (tog) begin
            if (m_cnt8 != 8'd255) m_cnt8 = m_cnt8 + 8'd1;
            if (m_cnt2 != 2'd3)   m_cnt2 = m_cnt2 + 2'd1;
         end
      end
      m_q    = nq;
      e.q    = nq;
      e.cnt8 = m_cnt8;
      e.sat8 = (m_cnt8 == 8'd255);
      e.cnt2 = m_cnt2;
      e.sat2 = (m_cnt2 == 2'd3);
`ifdef JK_REG_BANK_PARITY_EN
      e.par  = ^nq;
`else
      e.par  = 1'b0;
`endif
      sb.push_back(e);
      @(posedge clk);
      #2;
   endtask

   // Scoreboard: pop and compare one expectation per edge.
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_checks++;
         if ({q8, qn8, chg8, cnt8, sat8, par8} !== {e.q, ~e.q, e.chg, e.cnt8, e.sat8, e.par}) begin
            n_fail++;
            $display("FAIL sb_%s: dut q=%h qn=%h chg=%b cnt=%0d sat=%b par=%b, model q=%h qn=%h chg=%b cnt=%0d sat=%b par=%b",
                     e.tag, q8, qn8, chg8, cnt8, sat8, par8, e.q, ~e.q, e.chg, e.cnt8, e.sat8, e.par);
         end
         n_checks++;
         if ({q2, qn2, chg2, cnt2, sat2, par2} !== {e.q, ~e.q, e.chg, e.cnt2, e.sat2, e.par}) begin
            n_fail++;
            $display("FAIL sb2_%s: dut q=%h qn=%h chg=%b cnt=%0d sat=%b par=%b, model q=%h qn=%h chg=%b cnt=%0d sat=%b par=%b",
                     e.tag, q2, qn2, chg2, cnt2, sat2, par2, e.q, ~e.q, e.chg, e.cnt2, e.sat2, e.par);
         end
      end
   end

   task automatic set_in(input logic r, input logic l, input logic e_n, input logic [7:0] jj,
                         input logic [7:0] kk, input logic [7:0] dd, input logic cc);
      rst = r; load = l; en = e_n; j = jj; k = kk; d = dd; clr_cnt = cc;
   endtask

   task automatic test_reset;
      set_in(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'h5A, 1'b1);
      cyc("reset");
      n_checks++;
      if ({q8, qn8, chg8, cnt8, sat8} !== {8'h00, 8'hFF, 1'b0, 8'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset: q=%h qn=%h chg=%b cnt=%0d sat=%b, want 00 FF 0 0 0", q8, qn8, chg8, cnt8, sat8);
      end
   endtask

   task automatic test_jk_set_clear;
      set_in(1'b0, 1'b0, 1'b1, 8'hF0, 8'h0F, 8'h00, 1'b0);
      cyc("jk1");
      n_checks++;
      if ({q8, chg8} !== {8'hF0, 1'b1}) begin
         n_fail++;
         $display("FAIL jk_first: q=%h chg=%b, want F0 1", q8, chg8);
      end
      cyc("jk2");
      n_checks++;
      if ({q8, chg8} !== {8'hF0, 1'b0}) begin
         n_fail++;
         $display("FAIL jk_repeat: q=%h chg=%b, want F0 0", q8, chg8);
      end
   endtask

   task automatic test_toggle;
      logic [7:0] want [3];
      want[0] = 8'h0F; want[1] = 8'hF0; want[2] = 8'h0F;
      set_in(1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc("toggle");
         n_checks++;
         if (q8 !== want[i]) begin
            n_fail++;
            $display("FAIL toggle_%0d: q=%h, want %h", i, q8, want[i]);
         end
      end
      n_checks++;
      if (cnt8 !== 8'd3) begin
         n_fail++;
         $display("FAIL toggle_cnt: tog_cnt=%0d, want 3", cnt8);
      end
   endtask

   task automatic test_hold;
      set_in(1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0);
      cyc("hold");
      n_checks++;
      if ({q8, chg8, cnt8} !== {8'h0F, 1'b0, 8'd3}) begin
         n_fail++;
         $display("FAIL hold: q=%h chg=%b cnt=%0d, want 0F 0 3", q8, chg8, cnt8);
      end
   endtask

   task automatic test_load;
      logic par_want;
      set_in(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hA5, 1'b0);
      cyc("load_a5");
      n_checks++;
      if ({q8, cnt8, par8, chg8} !== {8'hA5, 8'd3, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL load_a5: q=%h cnt=%0d par=%b chg=%b, want A5 3 0 1", q8, cnt8, par8, chg8);
      end
      d = 8'hA4;
      cyc("load_a4");
`ifdef JK_REG_BANK_PARITY_EN
      par_want = 1'b1;
`else
      par_want = 1'b0;
`endif
      n_checks++;
      if ({q8, par8} !== {8'hA4, par_want}) begin
         n_fail++;
         $display("FAIL load_a4: q=%h par=%b, want A4 %b", q8, par8, par_want);
      end
      cyc("load_same");
      n_checks++;
      if ({q8, chg8} !== {8'hA4, 1'b0}) begin
         n_fail++;
         $display("FAIL load_same: q=%h chg=%b, want A4 0", q8, chg8);
      end
   endtask

   task automatic test_saturation;
      logic [1:0] want_cnt [5];
      want_cnt[0] = 2'd1; want_cnt[1] = 2'd2; want_cnt[2] = 2'd3; want_cnt[3] = 2'd3; want_cnt[4] = 2'd3;
      set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
      cyc("clr_idle");
      n_checks++;
      if ({cnt2, sat2, q2} !== {2'd0, 1'b0, 8'hA4}) begin
         n_fail++;
         $display("FAIL clr_idle: cnt=%0d sat=%b q=%h, want 0 0 A4", cnt2, sat2, q2);
      end
      set_in(1'b0, 1'b0, 1'b1, 8'h01, 8'h01, 8'h00, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc("sat");
         n_checks++;
         if ({cnt2, sat2} !== {want_cnt[i], (i >= 2)}) begin
            n_fail++;
            $display("FAIL sat_%0d: cnt=%0d sat=%b, want %0d %b", i, cnt2, sat2, want_cnt[i], (i >= 2));
         end
      end
      // A4 toggled bit0 five times -> A5; clearing must still let q toggle.
      clr_cnt = 1'b1;
      cyc("clr_tog");
      n_checks++;
      if ({cnt2, sat2, cnt8, q2, chg2} !== {2'd0, 1'b0, 8'd0, 8'hA4, 1'b1}) begin
         n_fail++;
         $display("FAIL clr_tog: cnt2=%0d sat=%b cnt8=%0d q=%h chg=%b, want 0 0 0 A4 1", cnt2, sat2, cnt8, q2, chg2);
      end
   endtask

   task automatic test_reset_override;
      set_in(1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'h00, 1'b0);
      cyc("pre_rst");
      set_in(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'h55, 1'b0);
      cyc("rst_over");
      n_checks++;
      if ({q8, cnt8, chg8, cnt2} !== {8'h00, 8'd0, 1'b0, 2'd0}) begin
         n_fail++;
         $display("FAIL rst_over: q=%h cnt=%0d chg=%b cnt2=%0d, want 00 0 0 0", q8, cnt8, chg8, cnt2);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 60; i++) begin
         set_in(($urandom_range(0, 19) == 0), ($urandom_range(0, 5) == 0), 1'($urandom),
                8'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 9) == 0));
         cyc("rand");
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      m_q = 8'h00; m_cnt8 = 8'd0; m_cnt2 = 2'd0;
      set_in(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      @(posedge clk);
      #2;
      test_reset();
      test_jk_set_clear();
      test_toggle();
      test_hold();
      test_load();
      test_saturation();
      test_reset_override();
      test_random();
      @(posedge clk);
      #2;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
